spi_master_fab: RTL and testbench
=================================

// Module: spi_master_fab
// PURPOSE
//  Fabric SPI master: a parametrised successor to the fixed MSS SPI_0 port set. Adds configurable word
//  width, slave-select count, all four CPOL/CPHA modes, clock divider and MSB/LSB-first order.
//  Sits in the FPGA fabric beside the MSS, driven by an APB-wrapper or fabric state machine through a
//  valid/ready word interface. One full-duplex word per transfer.
// PARAMETERS
//  DATA_W  8  bits per transfer (2..32)
//  NUM_SS  1  number of active-low slave selects (1..8); SEL_W = max(1,clog2(NUM_SS))
//  DIV_W   8  width of CFG_DIV
// PORTS
//  FAB_CLK        in   1       fabric clock, all logic rising-edge
//  MSS_RESET_N    in   1       asynchronous active-low reset
//  CFG_CPOL       in   1       SCLK idle level
//  CFG_CPHA       in   1       0: sample leading edge; 1: sample trailing edge
//  CFG_LSB_FIRST  in   1       1: shift LSB first
//  CFG_DIV        in   DIV_W   SCLK half-period H = CFG_DIV+1 FAB_CLK cycles
//  TX_DATA        in   DATA_W  word to send
//  TX_SS_SEL      in   SEL_W   slave index to select
//  TX_VALID       in   1       request transfer
//  TX_READY       out  1       block can accept request
//  RX_DATA        out  DATA_W  last received word
//  RX_VALID       out  1       one-cycle pulse: RX_DATA updated
//  BUSY           out  1       high in any state other than IDLE
//  SPI_CLK        out  1       serial clock
//  SPI_SS         out  NUM_SS  slave selects, active low
//  SPI_DO         out  1       MOSI
//  SPI_DI         in   1       MISO (synchronised internally is NOT done; caller guarantees timing)
// BEHAVIOUR
//  Reset (async): state IDLE, TX_READY=1, BUSY=0, RX_VALID=0, RX_DATA=0, SPI_SS=all 1, SPI_CLK=0,
//   SPI_DO=0, divider/bit counters 0. Reset mid-transfer aborts at once; no RX_VALID afterwards.
//  Handshake: accept on rising edge with TX_VALID&TX_READY; TX_READY=1 only in IDLE. TX_DATA,
//   TX_SS_SEL and all CFG_* captured at accept; CFG changes during a transfer have no effect.
//  IDLE: SPI_CLK = CFG_CPOL registered (one-cycle lag), SS all high, SPI_DO holds.
//  SETUP (H cycles): selected SS low; SPI_CLK=CPOL; CPHA=0 drives first bit on SPI_DO at entry.
//  XFER (2*DATA_W*H cycles): SPI_CLK toggles every H cycles, exactly 2*DATA_W edges, ends at CPOL.
//   CPHA=0: sample SPI_DI on leading edges, shift SPI_DO on trailing edges (not after last).
//   CPHA=1: drive SPI_DO on leading edges, sample on trailing edges.
//   Bit order per captured LSB_FIRST; RX shift register fills in the same order as TX.
//  HOLD (H cycles): SS still low, SPI_CLK=CPOL.
//  GAP (H cycles): SS all high; RX_DATA loaded and RX_VALID=1 on first GAP cycle only; then IDLE.
//  Latency: RX_VALID asserted (2*DATA_W+2)*H+1 cycles after the accepting edge; next accept
//   possible (2*DATA_W+3)*H cycles after accept, so SS high >= H cycles between words.
//  TX_SS_SEL >= NUM_SS: transfer runs normally, no SS line asserted.
//  CFG_DIV=0: H=1, SPI_CLK = FAB_CLK/2. CFG_DIV all-ones: H=2^DIV_W, counter must not overflow.
//  TX_VALID while BUSY: ignored, not queued; caller holds it until TX_READY.
// TESTING
//  1 Mode0, DIV=0, MSB, DO looped to DI, TX 0xA5 SS 0 -> RX_DATA 0xA5, RX_VALID at accept+19, 16 edges.
//  2 Mode3, DIV=3, LSB-first, slave model returns 0x3C -> MOSI bits 1,0,1,0,0,1,0,1; RX 0x3C; H=4.
//  3 Modes 1/2 with slave model checking sample edge, TX 0x81 -> slave sees 0x81, RX = slave word.
//  4 Back-to-back: TX_VALID held, 0x11 then 0x22 -> two RX_VALID pulses, SS high >= H cycles between.
//  5 Reset asserted mid-XFER (bit 4) -> SS all 1, SPI_CLK 0, TX_READY 1 same cycle, no RX_VALID.
//  6 NUM_SS=4, TX_SS_SEL=2 then 5 (SEL_W=2 wraps test with NUM_SS=3, sel=3) -> SS=4'b1011; then none low.

Source files
------------

// File: rtl/spi_master_fab.sv
// Fabric SPI master: one full-duplex word per valid/ready request, with configurable
// CPOL/CPHA, SCLK divider, bit order and slave select. All settings are latched at accept.
module spi_master_fab #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 1,
  parameter int DIV_W  = 8,
  parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic              fab_clk_i,
  input  logic              mss_reset_n_i,
  input  logic              cfg_cpol_i,
  input  logic              cfg_cpha_i,
  input  logic              cfg_lsb_first_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic [SEL_W-1:0]  tx_ss_sel_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  output logic              busy_o,
  output logic              spi_clk_o,
  output logic [NUM_SS-1:0] spi_ss_o,
  output logic              spi_do_o,
  input  logic              spi_di_i
);
  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d, do_q, do_d, rx_valid_q, rx_valid_d;
  logic [NUM_SS-1:0] ss_q, ss_d, ss_sel_dec;

  logic              tick, leading, last_edge, tx_next_bit;
  logic [DATA_W-1:0] tx_shifted, rx_sampled;

  assign tick        = (cnt_q == '0);
  assign leading     = ~edge_q[0];
  assign last_edge   = (edge_q == LAST_EDGE);
  assign tx_next_bit = lsb_q ? tx_sh_q[0] : tx_sh_q[DATA_W-1];
  assign tx_shifted  = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  assign rx_sampled  = lsb_q ? {spi_di_i, rx_sh_q[DATA_W-1:1]}
                             : {rx_sh_q[DATA_W-2:0], spi_di_i};

  // Out-of-range selects leave every line high.
  always_comb begin
    ss_sel_dec = '1;
    for (int i = 0; i < NUM_SS; i++)
      if (tx_ss_sel_i == SEL_W'(i)) ss_sel_dec[i] = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    do_d       = do_q;
    ss_d       = ss_q;
    rx_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        sclk_d = cfg_cpol_i;
        if (tx_valid_i) begin
          state_d = S_SETUP;
          cnt_d   = cfg_div_i;
          div_d   = cfg_div_i;
          cpol_d  = cfg_cpol_i;
          cpha_d  = cfg_cpha_i;
          lsb_d   = cfg_lsb_first_i;
          edge_d  = '0;
          rx_sh_d = '0;
          ss_d    = ss_sel_dec;
          tx_sh_d = tx_data_i;
          if (!cfg_cpha_i) begin
            do_d    = cfg_lsb_first_i ? tx_data_i[0] : tx_data_i[DATA_W-1];
            tx_sh_d = cfg_lsb_first_i ? (tx_data_i >> 1) : (tx_data_i << 1);
          end
        end
      end
      S_SETUP: begin
        if (tick) begin
          state_d = S_XFER;
          cnt_d   = div_q;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_XFER: begin
        if (tick) begin
          cnt_d  = div_q;
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          // Sample edge is leading for CPHA=0, trailing for CPHA=1; the other edge drives.
          if (leading != cpha_q) begin
            rx_sh_d = rx_sampled;
          end else if (!last_edge) begin
            do_d    = tx_next_bit;
            tx_sh_d = tx_shifted;
          end
          if (last_edge) state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (tick) begin
          state_d    = S_GAP;
          cnt_d      = div_q;
          ss_d       = '1;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
        else      cnt_d   = cnt_q - DIV_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge fab_clk_i or negedge mss_reset_n_i) begin
    if (!mss_reset_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      do_q       <= 1'b0;
      ss_q       <= '1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      do_q       <= do_d;
      ss_q       <= ss_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready_o = (state_q == S_IDLE);
  assign busy_o     = (state_q != S_IDLE);
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign spi_clk_o  = sclk_q;
  assign spi_ss_o   = ss_q;
  assign spi_do_o   = do_q;

endmodule

// File: tb/tb_spi_master_fab.sv
// Bench for spi_master_fab: a driver queues expected transfers, a monitor plays an SPI slave
// from the pins and checks each RX_VALID against the queued transfer.
module tb_spi_master_fab;
  localparam int DW  = 8;
  localparam int NSS = 5;
  localparam int DVW = 8;
  localparam int SW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cpol = 1'b0, cpha = 1'b0, lsb = 1'b0, tx_valid = 1'b0;
  logic [DVW-1:0] div = '0;
  logic [DW-1:0]  tx_data = '0;
  logic [SW-1:0]  sel = '0;
  logic           tx_ready, rx_valid, busy, spi_clk, spi_do, spi_di;
  logic [DW-1:0]  rx_data;
  logic [NSS-1:0] spi_ss;

  always #5 clk = ~clk;

  spi_master_fab #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DVW), .SEL_W(SW)) dut (
    .fab_clk_i(clk), .mss_reset_n_i(rst_n),
    .cfg_cpol_i(cpol), .cfg_cpha_i(cpha), .cfg_lsb_first_i(lsb), .cfg_div_i(div),
    .tx_data_i(tx_data), .tx_ss_sel_i(sel), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .busy_o(busy),
    .spi_clk_o(spi_clk), .spi_ss_o(spi_ss), .spi_do_o(spi_do), .spi_di_i(spi_di)
  );

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sw;
    bit         cpol, cpha, lsb, loopb;
    int         h;
    int         sel;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   checks = 0, passed = 0, cyc = 0;
  logic miso = 1'b0;

  assign spi_di = cur.loopb ? spi_do : miso;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic bit_of(input logic [7:0] w, input bit l, input int i);
    return l ? w[i] : w[7-i];
  endfunction

  function automatic logic [NSS-1:0] ss_exp(input int s);
    logic [NSS-1:0] r;
    r = '1;
    if (s < NSS) r[s] = 1'b0;
    return r;
  endfunction

  // Monitor + slave model
  bit         in_xfer = 0, seen_xfer = 0, ss_low_prev = 0, win_ok = 1;
  int         acc_cyc = 0, n_edges = 0, so_idx = 0, rx_bits = 0, hi_run = 0, last_h = 1;
  logic [7:0] slv_rx = '0;
  logic       prev_sclk = 1'b0;

  always @(negedge clk) begin
    int   rel;
    bit   lead;
    txn_t e;
    if (!rst_n) begin
      in_xfer = 0; seen_xfer = 0; hi_run = 0; ss_low_prev = 0;
    end else begin
      if (spi_ss != '1) begin
        if (!ss_low_prev && seen_xfer) chk("ss_gap_between_words", int'(hi_run >= last_h), 1);
        hi_run = 0; ss_low_prev = 1;
      end else begin
        hi_run++; ss_low_prev = 0;
      end
      if (in_xfer) begin
        rel = cyc - acc_cyc;
        if (rel >= 0 && rel < (2*DW+2)*cur.h)
          if (spi_ss !== ss_exp(cur.sel) || busy !== 1'b1 || tx_ready !== 1'b0) win_ok = 0;
        if (spi_clk !== prev_sclk) begin
          n_edges++;
          lead = (spi_clk != cur.cpol);
          if (lead != cur.cpha) begin
            if (rx_bits < 8) slv_rx[cur.lsb ? rx_bits : 7-rx_bits] = spi_do;
            rx_bits++;
          end else if (so_idx < 8) begin
            miso = bit_of(cur.sw, cur.lsb, so_idx);
            so_idx++;
          end
          prev_sclk = spi_clk;
        end
      end
      if (rx_valid) begin
        if (!in_xfer || exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_rx_valid: got rx_data %0h with no transfer pending", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("rx_data", int'(rx_data), int'(e.loopb ? e.tx : e.sw));
          chk("rx_latency", cyc - acc_cyc + 1, (2*DW+2)*e.h + 1);
          chk("sclk_edges", n_edges, 2*DW);
          chk("mosi_word_at_slave", int'(slv_rx), int'(e.tx));
          chk("ss_busy_window", int'(win_ok), 1);
          chk("ss_high_in_gap", int'(spi_ss), int'(ss_exp(NSS)));
          chk("sclk_ends_at_cpol", int'(spi_clk), int'(e.cpol));
          in_xfer = 0; seen_xfer = 1; last_h = e.h;
        end
      end
      if (tx_valid && tx_ready && exp_q.size() > 0) begin
        cur = exp_q[0];
        in_xfer = 1; acc_cyc = cyc + 1; n_edges = 0; so_idx = 0; rx_bits = 0;
        slv_rx = '0; prev_sclk = cur.cpol; win_ok = 1;
        if (!cur.cpha) begin
          miso = bit_of(cur.sw, cur.lsb, 0);
          so_idx = 1;
        end
      end
    end
  end

  task automatic send(input logic [7:0] t, input logic [7:0] s, input bit p, input bit a,
                      input bit l, input logic [7:0] d, input int sl, input bit lp, input bit hold);
    txn_t e;
    bit   acc = 0;
    int   n = 0;
    @(posedge clk); #1;
    cpol = p; cpha = a; lsb = l; div = d; tx_data = t; sel = SW'(sl);
    e.tx = t; e.sw = s; e.cpol = p; e.cpha = a; e.lsb = l; e.loopb = lp;
    e.h = int'(d) + 1; e.sel = sl;
    exp_q.push_back(e);
    tx_valid = 1'b1;
    while (!acc && n < 20000) begin
      @(negedge clk); acc = tx_ready; n++;
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++;
      $display("FAIL accept_timeout: tx_ready never seen for tx %0h", t);
      void'(exp_q.pop_back());
      tx_valid = 1'b0;
    end else if (!hold) begin
      // Disturb every captured input; the running transfer must not notice.
      tx_valid = 1'b0;
      cpol = 1'($urandom); cpha = 1'($urandom); lsb = 1'($urandom);
      div = 8'($urandom); tx_data = 8'($urandom); sel = 3'($urandom);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    tx_valid = 1'b0;
    while (exp_q.size() > 0 && n < 30000) begin @(negedge clk); n++; end
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL rx_timeout: %0d transfers still pending", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    chk("reset_tx_ready", int'(tx_ready), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_ss", int'(spi_ss), 31);
    chk("reset_sclk", int'(spi_clk), 0);
    chk("reset_do", int'(spi_do), 0);
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    send(8'hA5, 8'h00, 0, 0, 0, 8'd0, 0, 1, 0); wait_done();   // mode 0 loopback
    send(8'hA5, 8'h3C, 1, 1, 1, 8'd3, 0, 0, 0); wait_done();   // mode 3, LSB first
    send(8'h81, 8'h6E, 0, 1, 0, 8'd1, 1, 0, 0); wait_done();   // mode 1
    send(8'h81, 8'hD2, 1, 0, 0, 8'd2, 1, 0, 0); wait_done();   // mode 2
    send(8'h11, 8'h99, 0, 0, 0, 8'd0, 0, 0, 1);                // back-to-back
    send(8'h22, 8'h44, 0, 0, 0, 8'd0, 0, 0, 0); wait_done();
    send(8'h37, 8'hC8, 0, 0, 0, 8'd1, 2, 0, 0); wait_done();   // SS index 2
    send(8'h5B, 8'h00, 1, 1, 0, 8'd0, 5, 1, 0); wait_done();   // no slave selected
    send(8'hE4, 8'h00, 0, 1, 1, 8'd0, 7, 1, 0); wait_done();
    send(8'h5A, 8'h96, 1, 0, 0, 8'hFF, 1, 0, 0); wait_done();  // maximum divider

    for (int i = 0; i < 16; i++) begin
      send(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           8'($urandom_range(0, 4)), int'($urandom_range(0, 7)), 1'($urandom), 0);
      wait_done();
    end

    // Abort mid-transfer with an async reset
    send(8'hC3, 8'h5A, 0, 0, 0, 8'd1, 0, 0, 0);
    repeat (18) @(posedge clk);
    #2;
    chk("busy_before_reset", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ss", int'(spi_ss), 31);
    chk("abort_sclk", int'(spi_clk), 0);
    chk("abort_tx_ready", int'(tx_ready), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_rx_data", int'(rx_data), 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (3) @(posedge clk); #1; rst_n = 1'b1;
    repeat (100) @(posedge clk);

    send(8'h6D, 8'hB1, 1, 1, 0, 8'd1, 3, 0, 0); wait_done();   // recovery after abort

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
